// File: rtl/hsi_rx_deframer.sv
// HSI DRX deframer: DSYNC-framed serial bits to WORD_W words, output word FIFO and frame statistics.
// Define HSI_RX_PARITY_EN to accept a trailing even-parity bit per frame, reported on m_tuser.
module hsi_rx_deframer #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 3,
    parameter int FIFO_D = 8
) (
    input  logic              MCK,
    input  logic              RST_N,
    input  logic              en,
    input  logic              clr_stats,
    input  logic              DSYNC,
    input  logic              DRX,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              locked,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        ovf_cnt,
    output logic [7:0]        sync_err_cnt
);
    localparam int BW = $clog2(WORD_W);
    localparam int XW = $clog2(NWORDS + 1);
    localparam int AW = $clog2(FIFO_D);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
    localparam logic [XW-1:0] LAST_WORD = XW'(NWORDS - 1);

    typedef enum logic [1:0] {HUNT, SHIFT, WAIT_SYNC} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_good;
    logic [WORD_W-1:0]   r_sh;
    logic [BW-1:0]       r_bit_idx;
    logic [XW-1:0]       r_word_idx;
    logic                r_wr_en;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_wr_last;
    logic [WORD_W-1:0]   r_mem_data [FIFO_D];
    logic [FIFO_D-1:0]   r_mem_last;
    logic [AW:0]         r_wp;
    logic [AW:0]         r_rp;
    logic [15:0]         r_frame_cnt;
    logic [7:0]          r_ovf_cnt;
    logic [7:0]          r_sync_err_cnt;

    logic                w_start;
    logic                w_sample;
    logic                w_sync_err;
    logic                w_frame_done;
    logic                w_last_bit;
    logic                w_par_bit;
    logic                w_hold;
    logic                w_word_done;
    logic                w_par_push;
    logic                w_push;
    logic [WORD_W-1:0]   w_new_word;
    logic                w_pop;
    logic                w_full;
    logic                w_wr;
    logic                w_ovf;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_new_word = {r_sh[WORD_W-2:0], DRX};

`ifdef HSI_RX_PARITY_EN
    localparam logic [XW-1:0] PAR_SLOT = XW'(NWORDS);
    logic r_par;
    logic r_wr_user;
    logic [FIFO_D-1:0] r_mem_user;

    // The last data word waits in r_sh until the parity bit has been checked.
    assign w_par_bit  = (r_word_idx == PAR_SLOT);
    assign w_last_bit = w_par_bit;
    assign w_hold     = (r_word_idx == LAST_WORD);

    always_ff @(posedge MCK) begin
        if (w_start)
            r_par <= DRX;
        else if (w_sample && !w_par_bit)
            r_par <= r_par ^ DRX;
    end

    always_ff @(posedge MCK) begin
        if (w_push)
            r_wr_user <= w_par_push && (r_par ^ DRX);
        if (w_wr)
            r_mem_user[r_wp[AW-1:0]] <= r_wr_user;
    end

    assign m_tuser = m_tvalid & r_mem_user[r_rp[AW-1:0]];
`else
    assign w_par_bit  = 1'b0;
    assign w_last_bit = (r_word_idx == LAST_WORD) && (r_bit_idx == LAST_BIT);
    assign w_hold     = 1'b0;
    assign m_tuser    = 1'b0;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_start      = 1'b0;
        w_sample     = 1'b0;
        w_sync_err   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            HUNT: begin
                if (en && DSYNC) begin
                    w_state_nx = SHIFT;
                    w_start    = 1'b1;
                end
            end
            SHIFT: begin
                if (!en) begin
                    w_state_nx = HUNT;
                end else if (DSYNC && !w_last_bit) begin
                    w_sync_err = 1'b1;
                    w_start    = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (w_last_bit) begin
                        w_frame_done = 1'b1;
                        w_state_nx   = WAIT_SYNC;
                    end
                end
            end
            WAIT_SYNC: begin
                if (en && DSYNC) begin
                    w_state_nx = SHIFT;
                    w_start    = 1'b1;
                end else begin
                    w_state_nx = HUNT;
                end
            end
            default: w_state_nx = HUNT;
        endcase
    end

    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= HUNT;
            r_good  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx == HUNT)
                r_good <= 1'b0;
            else if (w_frame_done)
                r_good <= 1'b1;
        end
    end

    assign locked = r_good && (r_state != HUNT);

    assign w_word_done = w_sample && !w_par_bit && (r_bit_idx == LAST_BIT);
    assign w_par_push  = w_sample && w_par_bit;
    assign w_push      = (w_word_done && !w_hold) || w_par_push;

    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            r_bit_idx  <= '0;
            r_word_idx <= '0;
        end else if (w_start) begin
            r_bit_idx  <= BW'(1);
            r_word_idx <= '0;
        end else if (w_sample && !w_par_bit) begin
            if (r_bit_idx == LAST_BIT) begin
                r_bit_idx  <= '0;
                r_word_idx <= r_word_idx + 1'b1;
            end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge MCK) begin
        if (w_start || (w_sample && !w_par_bit))
            r_sh <= w_new_word;
    end

    // Completed word is staged one cycle before entering the FIFO.
    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N)
            r_wr_en <= 1'b0;
        else
            r_wr_en <= w_push;
    end

    always_ff @(posedge MCK) begin
        if (w_push) begin
            r_wr_data <= w_par_push ? r_sh : w_new_word;
            r_wr_last <= w_par_push || (r_word_idx == LAST_WORD);
        end
    end

    assign m_tvalid = (r_wp != r_rp);
    assign w_pop    = m_tvalid && m_tready;
    assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_wr     = r_wr_en && (!w_full || w_pop);
    assign w_ovf    = r_wr_en && !w_wr;

    always_ff @(posedge MCK) begin
        if (w_wr) begin
            r_mem_data[r_wp[AW-1:0]] <= r_wr_data;
            r_mem_last[r_wp[AW-1:0]] <= r_wr_last;
        end
    end

    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
        end
    end

    // Output gated so an empty FIFO presents zeros.
    assign m_tdata = m_tvalid ? r_mem_data[r_rp[AW-1:0]] : '0;
    assign m_tlast = m_tvalid & r_mem_last[r_rp[AW-1:0]];

    always_ff @(posedge MCK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_cnt    <= '0;
            r_ovf_cnt      <= '0;
            r_sync_err_cnt <= '0;
        end else if (clr_stats) begin
            r_frame_cnt    <= '0;
            r_ovf_cnt      <= '0;
            r_sync_err_cnt <= '0;
        end else begin
            if (w_frame_done)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_sync_err)
                r_sync_err_cnt <= sat_inc8(r_sync_err_cnt);
            if (w_ovf)
                r_ovf_cnt <= sat_inc8(r_ovf_cnt);
        end
    end

    assign frame_cnt    = r_frame_cnt;
    assign ovf_cnt      = r_ovf_cnt;
    assign sync_err_cnt = r_sync_err_cnt;

endmodule
